// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback scoreboard.
package rf_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // One writeback requester's payload
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Round-robin pointer: which requester wins the next tie
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with zero-latency grant.
//   clk, rst : clock, async active-high reset (forces grants low while asserted)
//   req[1:0] : requests from wb1/wb0
//   gnt[1:0] : one-hot grant, combinational from req and the pointer
// The pointer only moves on a tie, so a lone requester never disturbs fairness.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_state_e state_q, state_d;

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PRI0;
    else     state_q <= state_d;
  end

  // Grant decode and pointer update
  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    if (!rst) begin
      case (req)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          if (state_q == PRI0) begin
            gnt     = 2'b01;
            state_d = PRI1;
          end else begin
            gnt     = 2'b10;
            state_d = PRI0;
          end
        end
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_scoreboard.sv
// Issue scoreboard and shared REG_FILE write port.
//   iss_*      : decode-side instruction; iss_stall holds it on RAW/WAW hazards
//   wb0_*/wb1_*: writeback requesters (valid/rd/data in, ready out, zero latency)
//   rf_*       : REG_FILE write port (written on the falling edge after a grant)
//   sb_idle    : nothing in flight and nothing requesting
//   sb_err     : sticky flag for writeback to an idle register or to x0
module rf_wb_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_wen,
  output logic              iss_stall,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addrW,
  output logic [DATA_W-1:0] rf_din,
  output logic              sb_idle,
  output logic              sb_err
);

  wb_req_t           wb0, wb1, win;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              win_busy;
  logic              accepted;
  logic              sb_err_q;
  logic [NREG-1:0]   busy_q, busy_d, clr, set, eff_busy;

  assign wb0 = {wb0_valid, wb0_rd, wb0_data};
  assign wb1 = {wb1_valid, wb1_rd, wb1_data};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1.valid, wb0.valid}),
    .gnt (gnt)
  );

  // Write-port mux: granted payload, or all zeros
  always_comb begin
    win = '0;
    if (gnt[1])      win = wb1;
    else if (gnt[0]) win = wb0;
  end

  assign gnt_any  = |gnt;
  assign win_busy = busy_q[win.rd];

  // Clear only tracked registers; x0 is never busy so it never clears
  always_comb begin
    clr = '0;
    if (gnt_any && win_busy) clr[win.rd] = 1'b1;
  end

  // A register being written this cycle lands at negedge, so decode may use it now
  assign eff_busy = busy_q & ~clr;

  always_comb begin
    iss_stall = 1'b1;
    if (!rst) begin
      iss_stall = iss_valid &
                  (((iss_rs1 != '0) & eff_busy[iss_rs1]) |
                   ((iss_rs2 != '0) & eff_busy[iss_rs2]) |
                   (iss_rd_wen & (iss_rd != '0) & eff_busy[iss_rd]));
    end
  end

  assign accepted = iss_valid & ~iss_stall;

  always_comb begin
    set = '0;
    if (accepted && iss_rd_wen && (iss_rd != '0)) set[iss_rd] = 1'b1;
  end

  // New producer supersedes a same-cycle writeback to the same index
  always_comb begin
    busy_d    = (busy_q & ~clr) | set;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (gnt_any && !win_busy) sb_err_q <= 1'b1;
    end
  end

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign rf_wen    = gnt_any;
  assign rf_addrW  = win.rd;
  assign rf_din    = win.data;
  assign sb_err    = sb_err_q;
  assign sb_idle   = rst | ((busy_q == '0) & ~wb0_valid & ~wb1_valid);

endmodule
